// File: rtl/base_rr_arb_lock.sv
// Round-robin arbiter sharing one valid/ready channel; the grant is held for a
// whole packet (until an accepted req_last beat), with an optional stall watchdog.
module base_rr_arb_lock #(
    parameter int ways     = 4,
    parameter int id_width = (ways > 1) ? $clog2(ways) : 1,
    parameter int timeout  = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [0:ways-1]     req,
    input  logic [0:ways-1]     req_last,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [0:ways-1]     gnt,
    output logic [id_width-1:0] gnt_id,
    output logic                locked,
    output logic                timeout_err
);

    localparam int               CNT_W   = (timeout > 1) ? $clog2(timeout) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((timeout > 0) ? timeout - 1 : 0);
    localparam bit               WD_EN   = (timeout > 0);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [id_width-1:0] r_ptr;
    logic [id_width-1:0] r_lock_id;
    logic [CNT_W-1:0]    r_idle_cnt;
    logic                r_timeout_err;

    logic                w_found;
    logic [id_width-1:0] w_winner;
    logic [0:ways-1]     w_gnt;
    logic [id_width-1:0] w_gnt_id;
    logic                w_valid;
    logic                w_accept;
    logic                w_last;

    function automatic logic [id_width-1:0] f_next(input logic [id_width-1:0] id);
        logic [id_width-1:0] v_nxt;
        if (int'(id) >= ways - 1) begin
            v_nxt = '0;
        end else begin
            v_nxt = id + id_width'(1);
        end
        return v_nxt;
    endfunction

    // Winner search: first request at or above ptr, then wrap to the ones below it.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < ways; i++) begin
            w_winner = (!w_found && req[i] && (i >= int'(r_ptr))) ? id_width'(i) : w_winner;
            w_found  = w_found | (req[i] && (i >= int'(r_ptr)));
        end
        for (int i = 0; i < ways; i++) begin
            w_winner = (!w_found && req[i] && (i < int'(r_ptr))) ? id_width'(i) : w_winner;
            w_found  = w_found | (req[i] && (i < int'(r_ptr)));
        end
    end

    // Grant/valid decode; IDLE grants with zero latency, reset forces everything low.
    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        if (!reset_n) begin
            w_valid = 1'b0;
        end else if (r_state == ST_LOCKED) begin
            w_gnt[r_lock_id] = 1'b1;
            w_gnt_id         = r_lock_id;
            w_valid          = req[r_lock_id];
            w_last           = req_last[r_lock_id];
        end else if (w_found) begin
            w_gnt[w_winner] = 1'b1;
            w_gnt_id        = w_winner;
            w_valid         = 1'b1;
            w_last          = req_last[w_winner];
        end else begin
            w_valid = 1'b0;
        end
        w_accept = w_valid & out_ready;
    end

    // Arbitration state, rotating pointer and packet-stall watchdog.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_lock_id     <= '0;
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_idle_cnt <= '0;
                    if (w_found) begin
                        // An unaccepted beat also locks, so gnt cannot move under backpressure.
                        if (w_accept && w_last) begin
                            r_ptr <= f_next(w_winner);
                        end else begin
                            r_state   <= ST_LOCKED;
                            r_lock_id <= w_winner;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (req[r_lock_id]) begin
                        r_idle_cnt <= '0;
                        if (w_accept && w_last) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= f_next(r_lock_id);
                        end
                    end else if (WD_EN) begin
                        if (r_idle_cnt == CNT_MAX) begin
                            r_state       <= ST_IDLE;
                            r_ptr         <= f_next(r_lock_id);
                            r_idle_cnt    <= '0;
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_idle_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_idle_cnt <= '0;
                end
            endcase
        end
    end

    assign gnt         = w_gnt;
    assign gnt_id      = w_gnt_id;
    assign out_valid   = w_valid;
    assign locked      = (r_state == ST_LOCKED);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_base_rr_arb_lock.sv
// Scenario bench for base_rr_arb_lock: expected outputs are queued as each
// cycle's stimulus is applied and compared on the following falling edge.
module tb_base_rr_arb_lock;

    logic       clock;
    logic       reset_n;
    logic [0:3] req;
    logic [0:3] req_last;
    logic       out_ready;
    logic       out_valid;
    logic [0:3] gnt;
    logic [1:0] gnt_id;
    logic       locked;
    logic       timeout_err;

    typedef struct {
        logic [0:3] r;
        logic [0:3] l;
        logic       rdy;
        logic [0:3] g;
        logic       v;
        logic       lk;
        logic       te;
    } step_t;

    logic [8:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    base_rr_arb_lock #(.ways(4), .id_width(2), .timeout(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_last    (req_last),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {gnt, gnt_id, out_valid, locked, timeout_err}; the id is encoded from the expected grant
    function automatic logic [8:0] mk_exp(input logic [0:3] g, input logic v, input logic lk, input logic te);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) id = 2'(i);
        end
        return {g, id, v, lk, te};
    endfunction

    function automatic logic [8:0] obs();
        return {gnt, gnt_id, out_valid, locked, timeout_err};
    endfunction

    task automatic test_reset();
        logic [8:0] e, o;
        logic [0:3] g;
        reset_n = 1'b0; req = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        exp_q.push_back(mk_exp(4'b0000, 1'b0, 1'b0, 1'b0));
        @(negedge clock);
        o = obs(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_errors++;
            $display("FAIL reset_hold: got %b required %b", o, e);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = 4'b1000;
            g = g >> (k % 4);
            exp_q.push_back(mk_exp(g, 1'b1, 1'b0, 1'b0));
            @(negedge clock);
            o = obs(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL reset_rotate[%0d]: got %b required %b", k, o, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_rotation();
        step_t      tbl[$];
        logic [8:0] e, o;
        tbl.push_back('{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0});
        foreach (tbl[k]) begin
            req = tbl[k].r; req_last = tbl[k].l; out_ready = tbl[k].rdy;
            exp_q.push_back(mk_exp(tbl[k].g, tbl[k].v, tbl[k].lk, tbl[k].te));
            @(negedge clock);
            o = obs(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL rotation[%0d]: got %b required %b", k, o, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_packet_lock();
        step_t      tbl[$];
        logic [8:0] e, o;
        tbl.push_back('{4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{4'b1100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0});
        foreach (tbl[k]) begin
            req = tbl[k].r; req_last = tbl[k].l; out_ready = tbl[k].rdy;
            exp_q.push_back(mk_exp(tbl[k].g, tbl[k].v, tbl[k].lk, tbl[k].te));
            @(negedge clock);
            o = obs(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL packet_lock[%0d]: got %b required %b", k, o, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_backpressure();
        step_t      tbl[$];
        logic [8:0] e, o;
        tbl.push_back('{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{4'b1010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0});
        foreach (tbl[k]) begin
            req = tbl[k].r; req_last = tbl[k].l; out_ready = tbl[k].rdy;
            exp_q.push_back(mk_exp(tbl[k].g, tbl[k].v, tbl[k].lk, tbl[k].te));
            @(negedge clock);
            o = obs(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL backpressure[%0d]: got %b required %b", k, o, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_watchdog();
        step_t      tbl[$];
        logic [8:0] e, o;
        // owner 2 sends one beat then stalls for exactly 16 cycles
        tbl.push_back('{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 16; k++)
            tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{4'b1101, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0});
        foreach (tbl[k]) begin
            req = tbl[k].r; req_last = tbl[k].l; out_ready = tbl[k].rdy;
            exp_q.push_back(mk_exp(tbl[k].g, tbl[k].v, tbl[k].lk, tbl[k].te));
            @(negedge clock);
            o = obs(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL watchdog[%0d]: got %b required %b", k, o, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_async_reset();
        step_t      pre[$];
        step_t      post[$];
        logic [8:0] e, o;
        pre.push_back('{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0});
        pre.push_back('{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0});
        post.push_back('{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0});
        post.push_back('{4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0});
        foreach (pre[k]) begin
            req = pre[k].r; req_last = pre[k].l; out_ready = pre[k].rdy;
            exp_q.push_back(mk_exp(pre[k].g, pre[k].v, pre[k].lk, pre[k].te));
            @(negedge clock);
            o = obs(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL async_pre[%0d]: got %b required %b", k, o, e);
            end
            @(posedge clock); #1;
        end
        // assert reset between edges with the owner still requesting
        #2;
        reset_n = 1'b0;
        exp_q.push_back(mk_exp(4'b0000, 1'b0, 1'b0, 1'b0));
        #1;
        o = obs(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_errors++;
            $display("FAIL async_reset_drop: got %b required %b", o, e);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        foreach (post[k]) begin
            req = post[k].r; req_last = post[k].l; out_ready = post[k].rdy;
            exp_q.push_back(mk_exp(post[k].g, post[k].v, post[k].lk, post[k].te));
            @(negedge clock);
            o = obs(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL async_post[%0d]: got %b required %b", k, o, e);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset_n = 1'b0; req = 4'b0000; req_last = 4'b0000; out_ready = 1'b0;
        test_reset();
        test_rotation();
        test_packet_lock();
        test_backpressure();
        test_watchdog();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/base_rr_arb_lock.md
Name: base_rr_arb_lock

Overview:
Round-robin arbiter that shares one downstream valid/ready channel between `ways` requesters. Requester 0 is index-lowest; ties are broken circularly from a rotating priority pointer. A grant is held for a whole multi-beat packet, until a beat with `req_last` is accepted, so packets never interleave. An optional watchdog frees the channel if a granted requester stalls mid-packet.

Parameters:
ways, 4, number of requesters (>=1); vectors are indexed [0:ways-1].
id_width, $clog2(ways) (minimum 1), width of the encoded grant index.
timeout, 16, consecutive idle cycles a locked owner may hold the channel with req low before forced release; 0 disables the watchdog.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
req  in  [0:ways-1]  per-requester beat valid.
req_last  in  [0:ways-1]  per-requester last-beat flag; qualified by req.
out_ready  in  1  downstream accepts the current beat.
out_valid  out  1  downstream beat valid.
gnt  out  [0:ways-1]  one-hot grant; drives the datapath mux select.
gnt_id  out  id_width  encoded index of gnt; 0 when gnt is 0.
locked  out  1  arbiter is in LOCKED state.
timeout_err  out  1  single-cycle pulse on watchdog release.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, ptr=0, lock_id=0, idle_cnt=0, timeout_err=0.
  - gnt, gnt_id, out_valid and locked are forced to 0 while reset_n is low, even if req is high.
- Beat accept: a beat is accepted when out_valid & out_ready.
- Winner selection (combinational):
  - Winner is the first set req bit at index >= ptr.
  - If none, the first set req bit at index < ptr (wrap-around).
- IDLE state:
  - If req is 0: gnt=0, out_valid=0.
  - Otherwise gnt=onehot(winner) and out_valid=1 in the same cycle (zero-latency grant).
  - Accepted beat with req_last[winner]=1: ptr<=(winner+1) mod ways, stay in IDLE.
  - Accepted beat with req_last[winner]=0: go to LOCKED, lock_id<=winner.
  - Beat not accepted (out_ready=0): go to LOCKED, lock_id<=winner. This keeps gnt stable while out_valid is high and unaccepted.
- LOCKED state:
  - gnt=onehot(lock_id) continuously; out_valid=req[lock_id]; locked=1.
  - Requests from other requesters are ignored.
  - Accepted beat with req_last[lock_id]=1: ptr<=(lock_id+1) mod ways, go to IDLE. The next grant can issue in the following cycle.
  - Any cycle with req[lock_id]=1 clears idle_cnt to 0.
- Watchdog (timeout>0):
  - In LOCKED, each cycle with req[lock_id]=0 increments idle_cnt.
  - When idle_cnt reaches timeout-1 with req[lock_id] still 0: next cycle go to IDLE, ptr<=(lock_id+1) mod ways, timeout_err=1 for exactly 1 cycle, idle_cnt<=0.
  - The LOCKED-to-IDLE release cycle therefore follows `timeout` consecutive idle cycles.
  - With timeout=0, idle_cnt stays 0 and LOCKED waits indefinitely.
- Width and encoding:
  - idle_cnt is sized to hold timeout-1 and must never wrap.
  - gnt_id equals the binary encoding of gnt.
  - ptr arithmetic is modulo ways; ways=1 gives ptr constant 0.
- Simultaneous events:
  - In IDLE, a new winner's last beat and ptr update occur in the same cycle.
  - In LOCKED, a last-beat accept and watchdog expiry cannot coincide, because accept requires req high and req high clears idle_cnt.
- Invariants:
  - gnt is one-hot or 0; out_valid implies gnt!=0.
  - gnt never changes while out_valid=1 and out_ready=0.

Test Plan:
- Reset: hold reset_n=0 with req=4'b1111 -> gnt=0, out_valid=0; release with out_ready=1 and all req_last=1 -> grants 0,1,2,3,0 on consecutive cycles.
- Rotation: ptr=2 (after a grant to 1), req=4'b1001 -> gnt=4'b0001 (index 3); next cycle with req=4'b1001 -> index 0.
- Packet lock: req[1] sends a 3-beat packet (req_last only on beat 3) while req[0] is high throughout -> gnt stays 4'b0100 for all 3 beats, locked=1; index 0 granted the cycle after beat 3.
- Backpressure: in IDLE, req=4'b0010, out_ready=0 for 4 cycles, then req becomes 4'b1010 -> gnt holds 4'b0010 until accept; out_valid stays 1.
- Watchdog: timeout=16, owner 2 drops req mid-packet -> after 16 idle cycles locked=0 and timeout_err pulses once; the next grant goes to the first request at index >=3, wrapping.
- Async reset mid-packet while LOCKED with lock_id=3 -> locked, gnt and out_valid drop immediately with no clock; after release ptr=0 and req=4'b1001 -> index 0 granted.
